// File: rtl/square_rom_pkg.sv
// Shared types and square arithmetic for the square-lookup ROM.
// The squaring helper truncates to an arbitrary result width.
package square_rom_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int unsigned SQ_MAX_W = 32;

    // Square of the low addr_w bits of addr, reduced modulo 2**data_w.
    function automatic logic [2*SQ_MAX_W-1:0] sq_trunc(
        input logic [SQ_MAX_W-1:0] addr,
        input int unsigned         addr_w,
        input int unsigned         data_w
    );
        logic [2*SQ_MAX_W-1:0] a_ext;
        logic [2*SQ_MAX_W-1:0] a_mask;
        logic [2*SQ_MAX_W-1:0] d_mask;
        a_mask = (addr_w >= SQ_MAX_W) ? {{SQ_MAX_W{1'b0}}, {SQ_MAX_W{1'b1}}}
                                      : ((64'(1) << addr_w) - 64'(1));
        d_mask = (data_w >= 2*SQ_MAX_W) ? '1 : ((64'(1) << data_w) - 64'(1));
        a_ext  = {{SQ_MAX_W{1'b0}}, addr} & a_mask;
        return (a_ext * a_ext) & d_mask;
    endfunction

endpackage

// File: rtl/square_rom_seq_if.sv
// Request/sweep/result bundle for square_rom_seq.
// The master side is the address producer and the result consumer.
interface square_rom_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              sweep_start;
    logic [ADDR_W-1:0] sweep_first;
    logic [ADDR_W-1:0] sweep_last;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_addr, sweep_start, sweep_first, sweep_last, out_ready,
        input  in_ready, busy, out_valid, out_addr, out_data, out_last
    );

    modport slave (
        input  in_valid, in_addr, sweep_start, sweep_first, sweep_last, out_ready,
        output in_ready, busy, out_valid, out_addr, out_data, out_last
    );
endinterface

// File: rtl/square_lut.sv
// Combinational ADDR_W -> DATA_W square table; every address is defined.
module square_lut
    import square_rom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign data = DATA_W'(sq_trunc(SQ_MAX_W'(addr), ADDR_W, DATA_W));

endmodule

// File: rtl/square_rom_seq.sv
// Registered square ROM with valid/ready on both sides and a wrap-around
// sweep engine sharing one lookup table with the single-request path.
module square_rom_seq
    import square_rom_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    square_rom_seq_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;

    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;

    logic              adv;
    logic              in_ready_c;
    logic              load;
    logic              load_last;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;

    square_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lut (
        .addr (lut_addr),
        .data (lut_data)
    );

    // The slot may take new contents when empty or being drained this cycle.
    assign adv = !out_valid_q || bus.out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        in_ready_c = 1'b0;
        load       = 1'b0;
        load_last  = 1'b1;
        lut_addr   = bus.in_addr;

        unique case (state_q)
            IDLE: begin
                in_ready_c = adv && !bus.sweep_start;
                load       = bus.in_valid && in_ready_c;
                if (bus.sweep_start) begin
                    cur_d   = bus.sweep_first;
                    last_d  = bus.sweep_last;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                lut_addr  = cur_q;
                load_last = (cur_q == last_q);
                if (adv) begin
                    load  = 1'b1;
                    cur_d = cur_q + ADDR_W'(1);
                    if (load_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            if (adv) begin
                out_valid_q <= load;
                if (load) begin
                    out_addr_q <= lut_addr;
                    out_data_q <= lut_data;
                    out_last_q <= load_last;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = (state_q == SWEEP);
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_square_rom_seq.sv
// Scoreboard bench for square_rom_seq: a 4-bit and a 5-bit instance, each
// with its own expected-beat queue filled on issue and drained on handshake.
module tb_square_rom_seq;

    typedef struct {
        int addr;
        int data;
        bit last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    square_rom_seq_if #(.ADDR_W(4), .DATA_W(8)) ifc4 ();
    square_rom_seq_if #(.ADDR_W(5), .DATA_W(8)) ifc5 ();

    square_rom_seq #(.ADDR_W(4), .DATA_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));
    square_rom_seq #(.ADDR_W(5), .DATA_W(8)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(ifc5));

    beat_t q4[$];
    beat_t q5[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats4   = 0;
    int    beats5   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sq(input int a, input int dw);
        return (a * a) % (1 << dw);
    endfunction

    function automatic int qsize(input int sel);
        return (sel != 0) ? q5.size() : q4.size();
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? ifc5.in_ready : ifc4.in_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input int a, input int dw, input bit last);
        beat_t b;
        b.addr = a;
        b.data = exp_sq(a, dw);
        b.last = last;
        if (sel != 0) q5.push_back(b);
        else          q4.push_back(b);
    endtask

    task automatic set_in(input int sel, input logic v, input int a);
        if (sel != 0) begin ifc5.in_valid = v; ifc5.in_addr = 5'(a); end
        else          begin ifc4.in_valid = v; ifc4.in_addr = 4'(a); end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel != 0) ifc5.out_ready = r;
        else          ifc4.out_ready = r;
    endtask

    // Present one lookup until accepted; returns the cycles it took.
    task automatic send(input int sel, input int a, output int cycles);
        bit ok = 1'b0;
        cycles = 0;
        set_in(sel, 1'b1, a);
        while (!ok && cycles < 20) begin
            @(negedge clk);
            if (rdy(sel)) begin
                push(sel, a, 8, 1'b1);
                ok = 1'b1;
            end
            tick();
            cycles++;
        end
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    // Drive a sweep request for one cycle and queue its expected beats.
    task automatic start_sweep(input int sel, input int first, input int last, input int aw);
        int n;
        n = (((last - first) % (1 << aw)) + (1 << aw)) % (1 << aw) + 1;
        if (sel != 0) begin
            ifc5.sweep_first = 5'(first); ifc5.sweep_last = 5'(last); ifc5.sweep_start = 1'b1;
        end else begin
            ifc4.sweep_first = 4'(first); ifc4.sweep_last = 4'(last); ifc4.sweep_start = 1'b1;
        end
        for (int i = 0; i < n; i++) push(sel, (first + i) % (1 << aw), 8, i == n - 1);
        tick();
        ifc4.sweep_start = 1'b0;
        ifc5.sweep_start = 1'b0;
    endtask

    task automatic wait_drain(input int sel, input int budget, input bit toggle);
        int n = 0;
        logic r = 1'b1;
        while (qsize(sel) > 0 && n < budget) begin
            if (toggle) begin
                r = ~r;
                set_ready(sel, r);
            end
            tick();
            n++;
        end
        check((sel != 0) ? "d5_drain" : "d4_drain", 64'(qsize(sel)), 64'd0);
        set_ready(sel, 1'b1);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && ifc4.out_valid && ifc4.out_ready) begin
            beats4++;
            check("d4_sb_nonempty", 64'(q4.size() > 0), 64'd1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("d4_addr", 64'(ifc4.out_addr), 64'(e.addr));
                check("d4_data", 64'(ifc4.out_data), 64'(e.data));
                check("d4_last", 64'(ifc4.out_last), 64'(e.last));
            end
        end
        if (rst_n && ifc5.out_valid && ifc5.out_ready) begin
            beats5++;
            check("d5_sb_nonempty", 64'(q5.size() > 0), 64'd1);
            if (q5.size() > 0) begin
                e = q5.pop_front();
                check("d5_addr", 64'(ifc5.out_addr), 64'(e.addr));
                check("d5_data", 64'(ifc5.out_data), 64'(e.data));
                check("d5_last", 64'(ifc5.out_last), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int b;
        int busy_cnt;
        int vld_cnt;
        int a1[3] = '{0, 3, 15};

        ifc4.in_valid = 1'b0; ifc4.in_addr = '0; ifc4.sweep_start = 1'b0;
        ifc4.sweep_first = '0; ifc4.sweep_last = '0; ifc4.out_ready = 1'b0;
        ifc5.in_valid = 1'b0; ifc5.in_addr = '0; ifc5.sweep_start = 1'b0;
        ifc5.sweep_first = '0; ifc5.sweep_last = '0; ifc5.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ifc4.out_valid), 64'd0);
        check("rst_out_data",  64'(ifc4.out_data),  64'd0);
        check("rst_out_addr",  64'(ifc4.out_addr),  64'd0);
        check("rst_out_last",  64'(ifc4.out_last),  64'd0);
        check("rst_busy",      64'(ifc4.busy),      64'd0);
        rst_n = 1'b1;
        ifc4.out_ready = 1'b1;
        ifc5.out_ready = 1'b1;
        tick();

        // Back-to-back single lookups, one-cycle latency
        for (int i = 0; i < 3; i++) begin
            send(0, a1[i], cyc);
            check("t1_accept_first_cycle", 64'(cyc), 64'd1);
            check("t1_latency_valid", 64'(ifc4.out_valid), 64'd1);
            check("t1_latency_data", 64'(ifc4.out_data), 64'(exp_sq(a1[i], 8)));
        end
        set_in(0, 1'b0, 0);
        wait_drain(0, 10, 1'b0);
        tick();

        // Back-pressure holds the slot stable
        ifc4.out_ready = 1'b0;
        send(0, 7, cyc);
        set_in(0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 64'(ifc4.out_valid), 64'd1);
            check("t2_hold_data",  64'(ifc4.out_data),  64'd49);
            check("t2_in_ready",   64'(ifc4.in_ready),  64'd0);
            tick();
        end
        b = beats4;
        ifc4.out_ready = 1'b1;
        tick();
        check("t2_no_dup_valid", 64'(ifc4.out_valid), 64'd0);
        check("t2_one_beat", 64'(beats4 - b), 64'd1);

        // Sweep 2..5 at full rate
        b = beats4;
        start_sweep(0, 2, 5, 4);
        busy_cnt = 0;
        vld_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_cnt += int'(ifc4.busy);
            vld_cnt  += int'(ifc4.out_valid);
            tick();
        end
        check("t3_busy_cycles", 64'(busy_cnt), 64'd4);
        check("t3_valid_cycles", 64'(vld_cnt), 64'd4);
        check("t3_beats", 64'(beats4 - b), 64'd4);
        check("t3_queue_empty", 64'(q4.size()), 64'd0);

        // Wrap-around sweep with toggling out_ready
        b = beats4;
        start_sweep(0, 14, 1, 4);
        wait_drain(0, 40, 1'b1);
        check("t4_beats", 64'(beats4 - b), 64'd4);
        tick();
        tick();

        // Sweep wins over a simultaneous lookup
        ifc4.sweep_first = 4'd0; ifc4.sweep_last = 4'd2; ifc4.sweep_start = 1'b1;
        set_in(0, 1'b1, 9);
        @(negedge clk);
        check("t5_in_ready_blocked", 64'(ifc4.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) push(0, i, 8, i == 2);
        tick();
        ifc4.sweep_start = 1'b0;
        set_in(0, 1'b0, 0);
        wait_drain(0, 20, 1'b0);
        tick();
        check("t5_idle_after", 64'(ifc4.busy), 64'd0);
        send(0, 9, cyc);
        set_in(0, 1'b0, 0);
        wait_drain(0, 10, 1'b0);

        // Reset in the middle of a sweep
        start_sweep(0, 0, 15, 4);
        tick();
        tick();
        tick();
        check("t5_busy_mid", 64'(ifc4.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(ifc4.out_valid), 64'd0);
        check("t5_rst_busy",  64'(ifc4.busy),      64'd0);
        check("t5_rst_data",  64'(ifc4.out_data),  64'd0);
        q4.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_no_resume_valid", 64'(ifc4.out_valid), 64'd0);
        check("t5_no_resume_busy",  64'(ifc4.busy),      64'd0);

        // 5-bit instance: truncated single lookup and full-range sweep
        send(1, 31, cyc);
        set_in(1, 1'b0, 0);
        check("t6_single_data", 64'(ifc5.out_data), 64'd193);
        wait_drain(1, 10, 1'b0);
        tick();
        b = beats5;
        start_sweep(1, 0, 31, 5);
        wait_drain(1, 80, 1'b0);
        check("t6_full_beats", 64'(beats5 - b), 64'd32);
        tick();
        check("t6_idle_after", 64'(ifc5.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
